triangle_feeder: RTL and testbench
==================================

TRIANGLE_FEEDER -- requirements
Module: triangle_feeder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, vertex memory address width.
REQ-002 SHALL have parameter CNT_W, default 16, triangle count width.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_valid  in  1  job request.
- start_ready  out  1  job accepted when start_valid && start_ready.
- start_base  in  ADDR_W  address of the first vertex.
- start_count  in  CNT_W  triangle count.
- start_model  in  matrix_transform_t  model transform.
- start_camera  in  matrix_transform_t  camera transform.
- mem_rd_en  out  1  vertex read strobe.
- mem_addr  out  ADDR_W  vertex read address.
- mem_rd_data  in  vertex_t  read data, valid exactly 1 cycle after the strobe.
- out_setup  out  transform_setup_t  triangle, model and camera for the transformer.
- out_valid  out  1  out_setup valid.
- out_ready  in  1  downstream (transformer in_ready).
- done  out  1  one-cycle pulse at job end.
- busy  out  1  job in progress.

Function
REQ-004 SHALL implement the states IDLE, RD0, RD1, RD2, CAP and OUT.
REQ-005 SHALL drive start_ready=1 only in IDLE, and busy=1 in every state except IDLE.
REQ-006 On job accept, SHALL latch base, count, model and camera, and SHALL ignore start inputs until back in IDLE.
REQ-007 On accept with count>0, SHALL go to RD0; on accept with count==0, SHALL stay in IDLE, pulse done the next cycle and emit nothing.
REQ-008 In RD0, RD1 and RD2 SHALL assert mem_rd_en=1 with mem_addr set to the running address, then post-increment the address by 1.
REQ-009 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-010 mem_addr SHALL be 0 and mem_rd_en SHALL be 0 in every state other than RD0, RD1 and RD2.
REQ-011 SHALL capture mem_rd_data into triangle v0 in RD1, v1 in RD2 and v2 in CAP.
REQ-012 CAP SHALL go to OUT unconditionally.
REQ-013 In OUT, SHALL assert out_valid=1 and hold out_setup stable until out_ready=1.
REQ-014 out_setup.model and out_setup.camera SHALL equal the latched job values.
REQ-015 On the OUT handshake, SHALL decrement the remaining count.
REQ-016 After the OUT handshake, if the remaining count is nonzero SHALL go to RD0 the next cycle; otherwise SHALL go to IDLE and pulse done=1 for one cycle, coincident with the first IDLE cycle.
REQ-017 First-triangle latency SHALL be 5 cycles: out_valid is high in the 5th cycle after the accept edge.
REQ-018 Throughput SHALL be 5 cycles per triangle with out_ready held at 1.
REQ-019 Backpressure in OUT SHALL not issue memory reads and SHALL not alter the address or the count.
REQ-020 out_valid SHALL never depend combinationally on out_ready.
REQ-021 count = 2^CNT_W-1 SHALL emit exactly that many triangles, with no counter overflow.

Reset
REQ-022 rst=0 SHALL, asynchronously and at any time including mid-job, force IDLE.
REQ-023 While rst=0: out_valid=0, mem_rd_en=0, mem_addr=0, done=0, busy=0 and start_ready=0.
REQ-024 While rst=0, out_setup and all internal registers SHALL be 0.
REQ-025 A job interrupted by reset SHALL be discarded, with no done pulse.
REQ-026 The first job SHALL be accepted no earlier than the first rising edge after rst returns to 1.

Verification
REQ-027 Single triangle: base=0x0010, count=1, out_ready=1, memory[a]=a -> reads at 0x10, 0x11, 0x12; out_valid in cycle 5 with v0/v1/v2 = 0x10/0x11/0x12; done 1 cycle after the handshake.
REQ-028 Backpressure: count=2, out_ready=0 for 7 cycles in the first OUT -> out_setup stable and no mem_rd_en during the stall; the second triangle reads 0x13 to 0x15; exactly 2 handshakes.
REQ-029 Wrap: base=0xFFFE, count=1 -> addresses 0xFFFE, 0xFFFF, 0x0000.
REQ-030 Zero count: count=0 -> no mem_rd_en, no out_valid, done the cycle after accept, busy never 1.
REQ-031 Mid-job reset: rst=0 during RD1 of triangle 2 of 4 -> outputs 0 immediately, no done; a new job after release runs from its own base.
REQ-032 Busy ignore: start_valid held high throughout a 3-triangle job -> only one accept; the next accept occurs in the IDLE cycle after done.

Source files
------------

// File: rtl/triangle_feeder.sv
// Triangle feeder: fetches three vertices per triangle from vertex memory
// and hands each triangle, with its job transforms, to the transformer.
package triangle_feeder_pkg;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } vertex_t;

    typedef struct packed {
        logic [11:0][15:0] m;
    } matrix_transform_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } triangle_t;

    typedef struct packed {
        triangle_t         triangle;
        matrix_transform_t model;
        matrix_transform_t camera;
    } transform_setup_t;

endpackage

module triangle_feeder
    import triangle_feeder_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [ADDR_W-1:0] start_base,
    input  logic [CNT_W-1:0]  start_count,
    input  matrix_transform_t start_model,
    input  matrix_transform_t start_camera,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  vertex_t           mem_rd_data,
    output transform_setup_t  out_setup,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        CAP,
        OUT
    } state_e;

    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  ONE_C = CNT_W'(1);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rd_en_q;
    logic              valid_q;
    logic              done_q;
    logic              busy_q;
    logic              ready_q;
    transform_setup_t  setup_q;

    // addr_q always holds the next address to fetch; outputs are
    // registered, so each transition loads the values of the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            rd_en_q    <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            setup_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (start_valid && ready_q) begin
                        setup_q.model  <= start_model;
                        setup_q.camera <= start_camera;
                        cnt_q          <= start_count;
                        addr_q         <= start_base;
                        if (start_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q    <= RD0;
                            ready_q    <= 1'b0;
                            busy_q     <= 1'b1;
                            rd_en_q    <= 1'b1;
                            mem_addr_q <= start_base;
                            addr_q     <= start_base + ONE_A;
                        end
                    end
                end
                RD0: begin
                    state_q    <= RD1;
                    mem_addr_q <= addr_q;
                    addr_q     <= addr_q + ONE_A;
                end
                RD1: begin
                    setup_q.triangle.v0 <= mem_rd_data;
                    state_q    <= RD2;
                    mem_addr_q <= addr_q;
                    addr_q     <= addr_q + ONE_A;
                end
                RD2: begin
                    setup_q.triangle.v1 <= mem_rd_data;
                    state_q    <= CAP;
                    rd_en_q    <= 1'b0;
                    mem_addr_q <= '0;
                end
                CAP: begin
                    setup_q.triangle.v2 <= mem_rd_data;
                    state_q <= OUT;
                    valid_q <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        cnt_q   <= cnt_q - ONE_C;
                        if (cnt_q == ONE_C) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            state_q    <= RD0;
                            rd_en_q    <= 1'b1;
                            mem_addr_q <= addr_q;
                            addr_q     <= addr_q + ONE_A;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign start_ready = ready_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_addr    = mem_addr_q;
    assign out_setup   = setup_q;
    assign out_valid   = valid_q;
    assign done        = done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_triangle_feeder.sv
// Self-checking bench for triangle_feeder: directed table, corner
// sequences and randomized jobs against a reference model.
module tb_triangle_feeder;
    import triangle_feeder_pkg::*;

    localparam int SW = $bits(transform_setup_t);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start_valid = 1'b0;
    logic              start_ready;
    logic [15:0]       start_base = '0;
    logic [15:0]       start_count = '0;
    matrix_transform_t start_model = '0;
    matrix_transform_t start_camera = '0;
    logic              mem_rd_en;
    logic [15:0]       mem_addr;
    vertex_t           mem_rd_data;
    transform_setup_t  out_setup;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              done;
    logic              busy;

    always #5 clk = ~clk;

    triangle_feeder #(.ADDR_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_base(start_base), .start_count(start_count),
        .start_model(start_model), .start_camera(start_camera),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data),
        .out_setup(out_setup), .out_valid(out_valid),
        .out_ready(out_ready), .done(done), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // vertex memory: memory[a] has x = a
    function automatic vertex_t vmem(input logic [15:0] a);
        vertex_t v;
        v.x = a;
        v.y = a ^ 16'hA5A5;
        v.z = a + 16'h0101;
        return v;
    endfunction

    always @(posedge clk)
        mem_rd_data <= mem_rd_en ? vmem(mem_addr) : vertex_t'(48'hDEAD_0BAD_BEEF);

    // reference: triangle k of a job reads base+3k .. base+3k+2 (mod 2^16)
    function automatic transform_setup_t model_setup(input logic [15:0] base, input int k,
                                                     input matrix_transform_t m,
                                                     input matrix_transform_t c);
        transform_setup_t s;
        logic [15:0] a;
        a = base + 16'(3 * k);
        s.triangle.v0 = vmem(a);
        s.triangle.v1 = vmem(a + 16'd1);
        s.triangle.v2 = vmem(a + 16'd2);
        s.model = m;
        s.camera = c;
        return s;
    endfunction

    function automatic matrix_transform_t rand_mat();
        matrix_transform_t m;
        for (int i = 0; i < 12; i++) m.m[i] = 16'($urandom);
        return m;
    endfunction

    // monitor logs
    int               n_acc, n_done, first_v, stall_n, stall_bad;
    int               acc_q[$];
    int               done_cq[$];
    int               hs_cyc[$];
    logic [15:0]      rd_q[$];
    transform_setup_t out_q[$];
    bit               busy_seen, prev_stall;
    transform_setup_t prev_setup;

    task automatic clear_logs();
        n_acc = 0; n_done = 0; first_v = -1; stall_n = 0; stall_bad = 0;
        acc_q.delete(); done_cq.delete(); hs_cyc.delete();
        rd_q.delete(); out_q.delete();
        busy_seen = 0; prev_stall = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 0;
        end else begin
            if (start_valid && start_ready) begin n_acc++; acc_q.push_back(cyc); end
            if (mem_rd_en) rd_q.push_back(mem_addr);
            if (out_valid && first_v < 0) first_v = cyc;
            if (out_valid && out_ready) begin
                out_q.push_back(out_setup);
                hs_cyc.push_back(cyc);
            end
            if (done) begin n_done++; done_cq.push_back(cyc); end
            if (busy) busy_seen = 1;
            if (prev_stall && out_valid && out_setup !== prev_setup) stall_bad++;
            if (out_valid && mem_rd_en) stall_bad++;
            if (out_valid && !out_ready) stall_n++;
            prev_stall = out_valid && !out_ready;
            prev_setup = out_setup;
        end
    end

    // out_ready driver: 0 = always ready, 1 = random, 2 = stall first OUT
    int mode = 0;
    int stall_left = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    out_ready = (stall_left == 0);
                    if (out_valid && stall_left > 0) stall_left--;
                end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic wait_done(input int k);
        for (int t = 0; t < 4000 && n_done < k; t++) begin
            @(negedge clk);
            #1;
        end
        chk("done within budget", SW'(n_done >= k), SW'(1));
    endtask

    task automatic run_job(input logic [15:0] base, input logic [15:0] cnt,
                           input matrix_transform_t m, input matrix_transform_t c);
        bit seen;
        @(posedge clk);
        #1;
        start_base = base; start_count = cnt;
        start_model = m; start_camera = c;
        start_valid = 1'b1;
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            seen = start_ready;
        end
        chk("accept within budget", SW'(seen), SW'(1));
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        start_base = 16'hBAD0; start_count = 16'h7777;
        start_model = rand_mat(); start_camera = rand_mat();
        wait_done(1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_model(input string nm, input logic [15:0] base, input int cnt,
                               input matrix_transform_t m, input matrix_transform_t c);
        int errs;
        chk($sformatf("%s read count", nm), SW'(rd_q.size()), SW'(3 * cnt));
        errs = 0;
        foreach (rd_q[i]) if (rd_q[i] !== 16'(base + 16'(i))) errs++;
        chk($sformatf("%s read addresses", nm), SW'(errs), SW'(0));
        chk($sformatf("%s handshakes", nm), SW'(out_q.size()), SW'(cnt));
        for (int k = 0; k < cnt && k < out_q.size(); k++)
            chk($sformatf("%s triangle %0d", nm, k), out_q[k], model_setup(base, k, m, c));
    endtask

    typedef struct {
        logic [15:0] base;
        logic [15:0] cnt;
        int          stall;
        int          exp_reads;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
        int          exp_hs;
    } vec_t;

    vec_t vecs[6];

    initial begin
        matrix_transform_t m, c;
        int last;

        vecs[0] = '{16'h0010, 16'd1, 0, 3, 16'h0010, 16'h0012, 1};
        vecs[1] = '{16'h0010, 16'd2, 7, 6, 16'h0010, 16'h0015, 2};
        vecs[2] = '{16'hFFFE, 16'd1, 0, 3, 16'hFFFE, 16'h0000, 1};
        vecs[3] = '{16'h0040, 16'd0, 0, 0, 16'h0000, 16'h0000, 0};
        vecs[4] = '{16'h0100, 16'd3, 0, 9, 16'h0100, 16'h0108, 3};
        vecs[5] = '{16'hFFFD, 16'd2, 0, 6, 16'hFFFD, 16'h0002, 2};

        clear_logs();
        start_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ctrl outputs",
            SW'({out_valid, mem_rd_en, done, busy, start_ready, mem_addr}), SW'(0));
        chk("reset out_setup", out_setup, SW'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("no ready before first edge", SW'(start_ready), SW'(0));
        start_valid = 1'b0;

        for (int i = 0; i < 6; i++) begin
            m = rand_mat();
            c = rand_mat();
            mode = (vecs[i].stall > 0) ? 2 : 0;
            stall_left = vecs[i].stall;
            clear_logs();
            run_job(vecs[i].base, vecs[i].cnt, m, c);
            chk($sformatf("v%0d reads", i), SW'(rd_q.size()), SW'(vecs[i].exp_reads));
            if (vecs[i].exp_reads > 0 && rd_q.size() > 0) begin
                chk($sformatf("v%0d first addr", i), SW'(rd_q[0]), SW'(vecs[i].exp_first));
                chk($sformatf("v%0d last addr", i), SW'(rd_q[rd_q.size()-1]),
                    SW'(vecs[i].exp_last));
            end
            chk($sformatf("v%0d hs", i), SW'(out_q.size()), SW'(vecs[i].exp_hs));
            chk($sformatf("v%0d done pulses", i), SW'(n_done), SW'(1));
            chk($sformatf("v%0d busy seen", i), SW'(busy_seen), SW'(vecs[i].cnt != 0));
            chk($sformatf("v%0d stall cycles", i), SW'(stall_n), SW'(vecs[i].stall));
            chk($sformatf("v%0d stall hold", i), SW'(stall_bad), SW'(0));
            if (acc_q.size() > 0 && done_cq.size() > 0) begin
                if (vecs[i].cnt == 0) begin
                    chk($sformatf("v%0d no out_valid", i), SW'(first_v < 0), SW'(1));
                    chk($sformatf("v%0d done after accept", i),
                        SW'(done_cq[0] - acc_q[0]), SW'(1));
                end else begin
                    chk($sformatf("v%0d latency", i), SW'(first_v - acc_q[0]), SW'(5));
                    last = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] : 0;
                    chk($sformatf("v%0d done after hs", i), SW'(done_cq[0] - last), SW'(1));
                end
            end
            if (vecs[i].stall == 0 && hs_cyc.size() > 1)
                chk($sformatf("v%0d throughput", i), SW'(hs_cyc[1] - hs_cyc[0]), SW'(5));
            check_model($sformatf("v%0d", i), vecs[i].base, int'(vecs[i].cnt), m, c);
        end

        // reset during RD1 of triangle 2 of 4
        mode = 0;
        clear_logs();
        m = rand_mat();
        c = rand_mat();
        @(posedge clk);
        #1;
        start_base = 16'h0040; start_count = 16'd4;
        start_model = m; start_camera = c;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        for (int t = 0; t < 200 && rd_q.size() < 5; t++) begin
            @(negedge clk);
            #1;
        end
        chk("midrst reads before", SW'(rd_q.size()), SW'(5));
        if (rd_q.size() == 5) chk("midrst in RD1", SW'(rd_q[4]), SW'(16'h0044));
        rst = 1'b0;
        #1;
        chk("midrst ctrl outputs",
            SW'({out_valid, mem_rd_en, done, busy, start_ready, mem_addr}), SW'(0));
        chk("midrst out_setup", out_setup, SW'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst no done", SW'(n_done), SW'(0));
        clear_logs();
        m = rand_mat();
        c = rand_mat();
        run_job(16'h0200, 16'd1, m, c);
        check_model("after reset", 16'h0200, 1, m, c);

        // start_valid held high through a 3-triangle job
        clear_logs();
        m = rand_mat();
        c = rand_mat();
        @(posedge clk);
        #1;
        start_base = 16'h0300; start_count = 16'd3;
        start_model = m; start_camera = c;
        start_valid = 1'b1;
        wait_done(1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        wait_done(2);
        chk("hold accepts", SW'(n_acc), SW'(2));
        if (acc_q.size() > 1 && done_cq.size() > 0)
            chk("re-accept in done cycle", SW'(acc_q[1]), SW'(done_cq[0]));
        chk("hold hs", SW'(out_q.size()), SW'(6));
        for (int k = 0; k < 3 && k + 3 < out_q.size(); k++)
            chk($sformatf("hold second job tri %0d", k), out_q[k + 3],
                model_setup(16'h0300, k, m, c));

        // randomized jobs with random backpressure
        mode = 1;
        for (int j = 0; j < 8; j++) begin
            logic [15:0] b;
            int n;
            b = 16'($urandom);
            n = $urandom_range(1, 6);
            m = rand_mat();
            c = rand_mat();
            clear_logs();
            run_job(b, 16'(n), m, c);
            chk($sformatf("rand%0d done pulses", j), SW'(n_done), SW'(1));
            chk($sformatf("rand%0d stall hold", j), SW'(stall_bad), SW'(0));
            check_model($sformatf("rand%0d", j), b, n, m, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
